// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// reset PC, opcode field bounds and the sequential PC step.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_OUT   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          OP_MSB           = 31;
  localparam int          OP_LSB           = 26;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: async active-low reset, load of an aligned
// target (priority) or sequential increment, wrapping modulo 2^32.
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = word_align(load_val_i);
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding-request instruction fetch FSM with an IF/ID holding
// register and branch/jump redirect handling.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] pc_plus4_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output state_e      dbg_state_o
);

  // Decode handshake: an instruction transfers on a rising edge where
  // instr_valid_o and instr_ready_i are both high; instr_o/pc_plus4_o hold until then.

  state_e      state_d, state_q;
  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_plus4_d, pc_plus4_q;
  logic [31:0] pc;
  logic        pc_load, pc_inc;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (pc_load),
    .load_val_i (redirect_pc_i),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (redirect_i) begin
          pc_load = 1'b1;
          // A granted request is already in flight; its response must be drained.
          state_d = imem_gnt_i ? ST_DRAIN : ST_REQ;
        end else if (imem_gnt_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_i) begin
          pc_load = 1'b1;
          state_d = imem_rvalid_i ? ST_REQ : ST_DRAIN;
        end else if (imem_rvalid_i) begin
          instr_d    = imem_rdata_i;
          pc_plus4_d = pc + PC_INC;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (redirect_i) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end else if (instr_ready_i) begin
          pc_inc  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        pc_load = redirect_i;
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_REQ;
      instr_q    <= '0;
      pc_plus4_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  // Reset state is REQ, so the request is gated until reset is released.
  assign imem_req_o    = rst_i && (state_q == ST_REQ);
  assign imem_addr_o   = pc;
  assign instr_valid_o = (state_q == ST_OUT);
  assign instr_o       = instr_q;
  assign instr_op_o    = instr_q[OP_MSB:OP_LSB];
  assign pc_plus4_o    = pc_plus4_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: scoreboard queues of expected decode
// outputs, immediate-assertion checks, one summary line.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [5:0]  instr_op_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  state_e      dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc4_q[$];

  instr_fetch dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_op_o    (instr_op_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_e exp);
    check(tag, 32'(dbg_state_o), 32'(exp));
  endtask

  // Driver tasks
  task automatic do_req(input logic [31:0] addr);
    check("req_high", 32'(imem_req_o), 32'd1);
    check("req_addr", imem_addr_o, addr);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    check_state("in_wait", ST_WAIT);
  endtask

  task automatic do_resp(input logic [31:0] data);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
  endtask

  task automatic consume();
    logic [31:0] e_instr, e_pc4;
    check("valid_before_xfer", 32'(instr_valid_o), 32'd1);
    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e_instr = exp_q.pop_front();
      e_pc4   = exp_pc4_q.pop_front();
      check("instr", instr_o, e_instr);
      check("instr_op", 32'(instr_op_o), 32'(e_instr[31:26]));
      check("pc_plus4", pc_plus4_o, e_pc4);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    check("valid_after_xfer", 32'(instr_valid_o), 32'd0);
  endtask

  task automatic fetch_and_consume(input logic [31:0] addr, input logic [31:0] data);
    do_req(addr);
    exp_q.push_back(data);
    exp_pc4_q.push_back(addr + 32'd4);
    do_resp(data);
    consume();
  endtask

  initial begin
    logic [31:0] held;
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    #1 rst_i = 1'b0;
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc4", pc_plus4_o, 32'd0);
    check_state("rst_state", ST_REQ);
    tick();
    tick();
    rst_i = 1'b1;
    tick();

    // Basic fetch from reset PC
    do_req(32'h0);
    exp_q.push_back(32'h2002_0005);
    exp_pc4_q.push_back(32'h4);
    do_resp(32'h2002_0005);
    check("op_first", 32'(instr_op_o), 32'h08);
    consume();

    // Decode stall for 5 cycles, with a stray rvalid in OUT
    do_req(32'h4);
    exp_q.push_back(32'h8C41_0000);
    exp_pc4_q.push_back(32'h8);
    do_resp(32'h8C41_0000);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(instr_valid_o), 32'd1);
      check("stall_instr", instr_o, 32'h8C41_0000);
      check("stall_pc4", pc_plus4_o, 32'h8);
      check("stall_req", 32'(imem_req_o), 32'd0);
      imem_rvalid_i = (i == 2);
      imem_rdata_i  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid_i = 1'b0;
    end
    consume();

    // Redirect in WAIT -> DRAIN, drained data never shows up
    do_req(32'h8);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0043;
    tick();
    redirect_i = 1'b0;
    check_state("drain_entered", ST_DRAIN);
    check("drain_req", 32'(imem_req_o), 32'd0);
    do_resp(32'hBAD0_0001);
    check_state("drain_exit", ST_REQ);
    check("drain_valid", 32'(instr_valid_o), 32'd0);
    tick();
    check("drain_valid2", 32'(instr_valid_o), 32'd0);

    // Redirect in OUT together with ready: no transfer
    do_req(32'h40);
    do_resp(32'h1234_5678);
    check("out_valid", 32'(instr_valid_o), 32'd1);
    held          = 32'(exp_q.size());
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    instr_ready_i = 1'b1;
    tick();
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    check("redir_out_valid", 32'(instr_valid_o), 32'd0);
    check("redir_out_sb", 32'(exp_q.size()), held);
    fetch_and_consume(32'h100, 32'h0C00_0010);

    // Redirect in REQ without gnt, unaligned target forced aligned
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 1'b0;
    check_state("redir_req_state", ST_REQ);
    // PC wrap
    fetch_and_consume(32'hFFFF_FFFC, $urandom_range(32'h7FFF_FFFF, 0));

    // Redirect in WAIT coinciding with rvalid: data discarded
    do_req(32'h0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0002;
    tick();
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    check_state("wait_rv_redir", ST_REQ);
    check("wait_rv_valid", 32'(instr_valid_o), 32'd0);

    // Redirect in REQ with gnt -> DRAIN, second redirect in DRAIN
    check("req_gnt_addr", imem_addr_o, 32'h200);
    imem_gnt_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h300;
    tick();
    imem_gnt_i    = 1'b0;
    redirect_pc_i = 32'h400;
    check_state("req_gnt_drain", ST_DRAIN);
    tick();
    redirect_i = 1'b0;
    check_state("drain_hold", ST_DRAIN);
    do_resp(32'hBAD0_0003);
    check_state("drain_done", ST_REQ);

    // Reset during WAIT, late rvalid afterwards
    do_req(32'h400);
    rst_i = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req_o), 32'd0);
    check_state("midrst_state", ST_REQ);
    tick();
    rst_i = 1'b1;
    do_resp(32'hBAD0_0004);
    check("stale_valid", 32'(instr_valid_o), 32'd0);
    check_state("stale_state", ST_REQ);
    tick();
    check("stale_valid2", 32'(instr_valid_o), 32'd0);
    fetch_and_consume(32'h0, 32'hFC00_0001);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded at reset; low two bits SHALL be zero.
REQ-002 clk_i  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 imem_req_o  out  1  instruction-memory read request.
REQ-005 imem_addr_o  out  32  byte address of request (current PC).
REQ-006 imem_gnt_i  in  1  memory accepts request this cycle.
REQ-007 imem_rvalid_i  in  1  read data valid.
REQ-008 imem_rdata_i  in  32  instruction word.
REQ-009 instr_valid_o  out  1  instruction held for decode stage.
REQ-010 instr_o  out  32  held instruction word.
REQ-011 instr_op_o  out  6  instr_o[31:26], opcode feeding the decoder.
REQ-012 pc_plus4_o  out  32  address of held instruction + 4.
REQ-013 instr_ready_i  in  1  decode stage consumes held instruction.
REQ-014 redirect_i  in  1  taken branch / jump; overrides fetch.
REQ-015 redirect_pc_i  in  32  new fetch address; bits [1:0] SHALL be forced to 0.

Function
REQ-016 FSM states SHALL be REQ, WAIT, OUT, DRAIN; exactly one outstanding memory request.
REQ-017 REQ: imem_req_o=1, imem_addr_o=pc; on imem_gnt_i -> WAIT; else stay REQ with stable address.
REQ-018 WAIT: on imem_rvalid_i capture imem_rdata_i into instr_o, pc_plus4_o=pc+4, -> OUT.
REQ-019 OUT: instr_valid_o=1, instr_o and pc_plus4_o SHALL be stable until handshake; on instr_ready_i: pc<=pc+4, -> REQ.
REQ-020 Handshake: transfer occurs only when instr_valid_o and instr_ready_i are both 1 on a rising edge; minimum fetch period 3 cycles with zero-wait memory.
REQ-021 Redirect in REQ without gnt: pc<=redirect_pc_i, stay REQ.
REQ-022 Redirect in REQ with gnt same cycle, or in WAIT without rvalid: pc<=redirect_pc_i, -> DRAIN.
REQ-023 Redirect in WAIT with rvalid same cycle: data discarded, pc<=redirect_pc_i, -> REQ.
REQ-024 Redirect in OUT (with or without ready): held instruction dropped, instr_valid_o=0 next cycle, pc<=redirect_pc_i, -> REQ; redirect wins over pc+4.
REQ-025 DRAIN: imem_req_o=0; on imem_rvalid_i data discarded, -> REQ; further redirect in DRAIN updates pc only.
REQ-026 PC arithmetic modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 imem_rvalid_i in REQ or OUT SHALL be ignored (no state or output change).
REQ-028 instr_valid_o SHALL be 1 only in OUT.

Reset
REQ-029 On rst_i=0, immediately: state=REQ, pc=RESET_PC, instr_valid_o=0, instr_o=0, pc_plus4_o=0, imem_req_o=0.
REQ-030 imem_req_o SHALL assert combinationally from state REQ only after rst_i deasserts; first request address RESET_PC.
REQ-031 Reset mid-transaction abandons any outstanding response; a stale rvalid after reset in REQ is ignored per REQ-027.

Structure
REQ-032 Shared package SHALL hold state encoding, RESET_PC default, opcode field bounds [31:26], and PC increment constant 4.
REQ-033 PC register with async active-low reset and load/increment SHALL be sub-module pc_reg; FSM and IF/ID holding register in instr_fetch.

Verification
REQ-034 Reset release, gnt=1 and rvalid next cycle with 0x2002_0005, ready=1 -> addr 0x0 issued, instr_op_o=6'h08, pc_plus4_o=0x4, next request addr 0x4.
REQ-035 ready=0 for 5 cycles in OUT -> instr_o, pc_plus4_o stable, instr_valid_o=1, imem_req_o=0 throughout.
REQ-036 redirect_i=1, redirect_pc_i=0x0000_0043 while WAIT -> DRAIN; following rvalid data never appears; next request addr 0x40.
REQ-037 redirect in OUT concurrent with ready=1, target 0x100 -> no transfer counted, next request addr 0x100.
REQ-038 pc=0xFFFF_FFFC, fetch and consume -> next request addr 0x0000_0000.
REQ-039 rst_i=0 asserted during WAIT, released, late rvalid arrives -> ignored, request addr RESET_PC, instr_valid_o stays 0.
